// File: rtl/microsequencer.sv
// Microsequencer: next-address engine for the SPARC control unit.
// Ports: clk/reset, N/Inv/S/CR fields, MOC/Cond/IMM/dec_state in; state/inc_state/sts/illegal/mem_timeout out.
module microsequencer #(
  parameter int          TIMEOUT    = 15,
  parameter logic [4:0]  TRAP_STATE = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] N,
  input  logic       Inv,
  input  logic [1:0] S,
  input  logic [4:0] CR,
  input  logic       MOC,
  input  logic       Cond,
  input  logic       IMM,
  input  logic [4:0] dec_state,
  output logic [4:0] state,
  output logic [4:0] inc_state,
  output logic       sts,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

  logic       csel;
  logic [4:0] nxt;
  logic [7:0] wcnt;
  logic       hold;
  logic       trap;

  always_comb begin
    csel = 1'b0;
    unique case (S)
      2'b00: csel = MOC;
      2'b01: csel = Cond;
      2'b10: csel = IMM;
      2'b11: csel = 1'b0;
    endcase
  end

  assign sts = csel ^ Inv;

  always_comb begin
    nxt = 5'd0;
    unique case (N)
      3'b000: nxt = dec_state;
      3'b001: nxt = 5'd0;
      3'b010: nxt = CR;
      3'b011: nxt = inc_state;
      3'b100: nxt = sts ? CR : inc_state;
      3'b101: nxt = sts ? state : inc_state;
      3'b110: nxt = sts ? CR : dec_state;
      3'b111: nxt = 5'd0;
    endcase
  end

  // A hold that has lasted TIMEOUT edges is forced to the trap address.
  assign hold = (N == 3'b101) && sts;
  assign trap = hold && (wcnt == WLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= 5'd0;
      inc_state   <= 5'd1;
      wcnt        <= 8'd0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (trap) begin
      state       <= TRAP_STATE;
      inc_state   <= TRAP_STATE + 5'd1;
      wcnt        <= 8'd0;
      mem_timeout <= 1'b1;
    end else begin
      state       <= nxt;
      inc_state   <= nxt + 5'd1;
      wcnt        <= hold ? wcnt + 8'd1 : 8'd0;
      mem_timeout <= 1'b0;
      if (N == 3'b111)
        illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Testbench for microsequencer: directed steps with a queue of expected results.
// Expected register values are pushed before each edge and checked after it.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] N;
  logic       Inv;
  logic [1:0] S;
  logic [4:0] CR;
  logic       MOC, Cond, IMM;
  logic [4:0] dec_state;
  logic [4:0] state, inc_state;
  logic       sts, illegal, mem_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] st;
    logic [4:0] inc;
    logic       ill;
    logic       mt;
    string      tag;
  } exp_t;

  exp_t q[$];

  microsequencer #(.TIMEOUT(4), .TRAP_STATE(5'd31)) dut (
    .clk(clk), .reset(reset), .N(N), .Inv(Inv), .S(S), .CR(CR),
    .MOC(MOC), .Cond(Cond), .IMM(IMM), .dec_state(dec_state),
    .state(state), .inc_state(inc_state), .sts(sts),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sts(input logic exp, input string tag);
    #1;
    chk({tag, ".sts"}, {7'd0, sts}, {7'd0, exp});
  endtask

  // Push the expectation for the coming edge, clock it, pop and compare.
  task automatic go(input logic [4:0] st, input logic [4:0] inc,
                    input logic ill, input logic mt, input string tag);
    exp_t e;
    e.st = st; e.inc = inc; e.ill = ill; e.mt = mt; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".state"}, {3'd0, state}, {3'd0, e.st});
      chk({e.tag, ".inc"}, {3'd0, inc_state}, {3'd0, e.inc});
      chk({e.tag, ".illegal"}, {7'd0, illegal}, {7'd0, e.ill});
      chk({e.tag, ".mem_timeout"}, {7'd0, mem_timeout}, {7'd0, e.mt});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; N = 3'b010; Inv = 1'b0; S = 2'b00; CR = 5'd7;
    MOC = 1'b0; Cond = 1'b0; IMM = 1'b0; dec_state = 5'd0;
    #2;
    go(5'd0, 5'd1, 1'b0, 1'b0, "reset1");
    go(5'd0, 5'd1, 1'b0, 1'b0, "reset2");
    reset = 1'b0;

    // Sequential with wrap
    N = 3'b010; CR = 5'd30;
    go(5'd30, 5'd31, 1'b0, 1'b0, "load30");
    N = 3'b011;
    go(5'd31, 5'd0, 1'b0, 1'b0, "inc31");
    go(5'd0, 5'd1, 1'b0, 1'b0, "wrap0");

    // Conditional branch, Inv=0
    N = 3'b010; CR = 5'd4;
    go(5'd4, 5'd5, 1'b0, 1'b0, "load4a");
    N = 3'b100; S = 2'b01; Inv = 1'b0; Cond = 1'b1; CR = 5'd12;
    chk_sts(1'b1, "br_c1");
    go(5'd12, 5'd13, 1'b0, 1'b0, "br_c1");
    N = 3'b010; CR = 5'd4;
    go(5'd4, 5'd5, 1'b0, 1'b0, "load4b");
    N = 3'b100; Cond = 1'b0; CR = 5'd12;
    chk_sts(1'b0, "br_c0");
    go(5'd5, 5'd6, 1'b0, 1'b0, "br_c0");

    // Conditional branch, Inv=1
    N = 3'b010; CR = 5'd4;
    go(5'd4, 5'd5, 1'b0, 1'b0, "load4c");
    N = 3'b100; Inv = 1'b1; Cond = 1'b1; CR = 5'd12;
    chk_sts(1'b0, "brinv_c1");
    go(5'd5, 5'd6, 1'b0, 1'b0, "brinv_c1");
    N = 3'b010; CR = 5'd4;
    go(5'd4, 5'd5, 1'b0, 1'b0, "load4d");
    N = 3'b100; Cond = 1'b0; CR = 5'd12;
    chk_sts(1'b1, "brinv_c0");
    go(5'd12, 5'd13, 1'b0, 1'b0, "brinv_c0");

    // IMM select and constant-zero select
    N = 3'b100; S = 2'b10; Inv = 1'b0; IMM = 1'b1; CR = 5'd20;
    chk_sts(1'b1, "imm1");
    go(5'd20, 5'd21, 1'b0, 1'b0, "imm1");
    S = 2'b11;
    chk_sts(1'b0, "s11");
    go(5'd21, 5'd22, 1'b0, 1'b0, "s11");
    IMM = 1'b0;

    // N=110: CR on sts, else decoder address
    N = 3'b110; S = 2'b01; Cond = 1'b1; CR = 5'd3; dec_state = 5'd25;
    go(5'd3, 5'd4, 1'b0, 1'b0, "n110_t");
    Cond = 1'b0;
    go(5'd25, 5'd26, 1'b0, 1'b0, "n110_f");

    // Memory wait, MOC arrives before the watchdog
    N = 3'b010; CR = 5'd9;
    go(5'd9, 5'd10, 1'b0, 1'b0, "load9");
    N = 3'b101; S = 2'b00; Inv = 1'b1; MOC = 1'b0;
    go(5'd9, 5'd10, 1'b0, 1'b0, "wait1");
    go(5'd9, 5'd10, 1'b0, 1'b0, "wait2");
    go(5'd9, 5'd10, 1'b0, 1'b0, "wait3");
    MOC = 1'b1;
    go(5'd10, 5'd11, 1'b0, 1'b0, "wait_exit");

    // Watchdog trap after 4 hold edges
    MOC = 1'b0;
    go(5'd10, 5'd11, 1'b0, 1'b0, "wd1");
    go(5'd10, 5'd11, 1'b0, 1'b0, "wd2");
    go(5'd10, 5'd11, 1'b0, 1'b0, "wd3");
    go(5'd31, 5'd0, 1'b0, 1'b1, "wd_trap");
    go(5'd31, 5'd0, 1'b0, 1'b0, "wd_after");
    N = 3'b011;
    go(5'd0, 5'd1, 1'b0, 1'b0, "wd_leave");

    // Decode, then illegal (sticky)
    N = 3'b000; dec_state = 5'd17;
    go(5'd17, 5'd18, 1'b0, 1'b0, "decode");
    N = 3'b111;
    go(5'd0, 5'd1, 1'b1, 1'b0, "illegal");
    N = 3'b011;
    go(5'd1, 5'd2, 1'b1, 1'b0, "ill_sticky");
    N = 3'b001;
    go(5'd0, 5'd1, 1'b1, 1'b0, "fetch");

    // Reset mid-wait discards the count
    N = 3'b010; CR = 5'd5;
    go(5'd5, 5'd6, 1'b1, 1'b0, "load5");
    N = 3'b101; S = 2'b00; Inv = 1'b1; MOC = 1'b0;
    go(5'd5, 5'd6, 1'b1, 1'b0, "rw1");
    go(5'd5, 5'd6, 1'b1, 1'b0, "rw2");
    reset = 1'b1;
    go(5'd0, 5'd1, 1'b0, 1'b0, "rw_reset");
    reset = 1'b0;
    go(5'd0, 5'd1, 1'b0, 1'b0, "rw_h1");
    go(5'd0, 5'd1, 1'b0, 1'b0, "rw_h2");
    go(5'd0, 5'd1, 1'b0, 1'b0, "rw_h3");
    go(5'd31, 5'd0, 1'b0, 1'b1, "rw_trap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state engine of the SPARC control unit. Each cycle it consumes the registered transition fields produced by the control register (N, Inv, S, CR), selects and optionally inverts a status condition, and loads the 5-bit microstore address (`state`) for the next cycle. It also maintains the incrementer register and a memory-wait watchdog that traps stalled memory operations. `state` drives the microstore ROM address directly.

## Interface
- `TIMEOUT`, 15: consecutive hold cycles allowed before a memory-wait trap (1..255).
- `TRAP_STATE`, 5'd31: microstore address loaded on watchdog expiry.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `N`  in  3  next-state selector, N2..N0 from the control register.
- `Inv`  in  1  condition invert, from the control register.
- `S`  in  2  condition select, S1..S0 from the control register.
- `CR`  in  5  control-register branch target, CR4..CR0.
- `MOC`  in  1  memory operation complete.
- `Cond`  in  1  branch condition from the condition evaluator.
- `IMM`  in  1  IR bit 13 (immediate-operand flag).
- `dec_state`  in  5  instruction-decoder (encoder) start address.
- `state`  out  5  current microstore address (registered).
- `inc_state`  out  5  incrementer register, `state`+1 mod 32 (registered).
- `sts`  out  1  selected condition after inversion (combinational).
- `illegal`  out  1  sticky flag: N=111 was encountered.
- `mem_timeout`  out  1  one-cycle pulse on watchdog trap.

## Operation
- Condition mux: S=00 → MOC, 01 → Cond, 10 → IMM, 11 → 0. `sts` = selected XOR Inv.
- Next-address select, by N:
  - 000: `dec_state`.
  - 001: 0 (fetch).
  - 010: CR.
  - 011: `inc_state`.
  - 100: `sts` ? CR : `inc_state`.
  - 101 (wait): `sts` ? `state` (hold) : `inc_state`.
  - 110: `sts` ? CR : `dec_state`.
  - 111: 0, and set `illegal`.
- On every non-reset edge: `state` ← selected address; `inc_state` ← (selected address + 1) mod 32. 31 wraps to 0; no carry out.
- Watchdog:
  - `wcnt` is an 8-bit internal counter. It increments on each edge where N=101 and `sts`=1.
  - It clears on any other edge.
  - When N=101, `sts`=1 and `wcnt`=TIMEOUT−1, the edge loads `state` ← TRAP_STATE, `inc_state` ← TRAP_STATE+1 mod 32 and `wcnt` ← 0. `mem_timeout` is 1 for that following cycle only.
  - The trap overrides the hold.
- `illegal` stays at 1 until reset. It has no effect on sequencing beyond the forced 0.

## Timing
- Reset (edge with `reset`=1) wins over all other inputs. After it: `state`=0, `inc_state`=1, `wcnt`=0, `illegal`=0, `mem_timeout`=0.
- Reset asserted mid-wait or mid-trap discards the count. No trap pulse is issued.
- Latency: the inputs sampled at edge k determine `state` from edge k onward. There is one cycle from a control-register field to the address change.
- `sts` is combinational from the current inputs. All other outputs are registered and glitch-free.
- A hold keeps `state` and `inc_state` unchanged each cycle until `sts` falls or the watchdog fires.
- With the typical wait encoding (S=00, Inv=1), MOC rising at edge k exits the hold at edge k, and `state` becomes the old `inc_state`.
- Simultaneous N=111 with watchdog condition is impossible, because the watchdog requires N=101.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with N=010, CR=7 → `state`=0, `inc_state`=1, `illegal`=0, `mem_timeout`=0.
- Sequential and wrap: load CR=30 via N=010, then N=011 for 2 cycles → `state` 30, 31, 0. `inc_state` 31, 0, 1.
- Conditional branch: `state`=4, N=100, S=01, Inv=0. With Cond=1 and CR=12 → `state`=12. With Cond=0 → `state`=5. Repeat with Inv=1 → results swapped.
- Memory wait: `state`=9, N=101, S=00, Inv=1, MOC=0 for 3 cycles, then MOC=1 → `state` holds at 9 for 3 cycles, then becomes 10, with `mem_timeout`=0.
- Watchdog: TIMEOUT=4, N=101, S=00, Inv=1, MOC held 0 → `state` holds for 3 edges. The 4th edge loads `state`=31, `inc_state`=0, and `mem_timeout`=1 for exactly one cycle.
- Decode/illegal: N=000 with `dec_state`=17 → `state`=17. Then N=111 → `state`=0 and `illegal`=1, which persists until reset.
